// File: rtl/icache_responder_pkg.sv
// Shared types for the instruction cache: address split, frame layout and FSM states.
package icache_responder_pkg;

    localparam int unsigned WORD_W            = 32;
    localparam int unsigned ADDR_SPACE_WIDTH  = 16;
    localparam int unsigned ICACHE_FRAMES     = 8;
    localparam int unsigned LOG_ICACHE_FRAMES = 3;
    localparam int unsigned BLOCK_WORDS       = 2;
    localparam int unsigned BYTE_OFF_W        = 2;
    localparam int unsigned BLOCK_OFF_W       = 1;
    localparam int unsigned ICACHE_TAG_W      = ADDR_SPACE_WIDTH - LOG_ICACHE_FRAMES
                                                - BLOCK_OFF_W - BYTE_OFF_W;
    localparam int unsigned CNT_W             = 16;

    typedef logic [WORD_W-1:0]            word_t;
    typedef logic [ICACHE_TAG_W-1:0]      icache_tag_t;
    typedef logic [LOG_ICACHE_FRAMES-1:0] icache_index_t;

    typedef struct packed {
        logic                        valid;
        icache_tag_t                 tag;
        word_t [BLOCK_WORDS-1:0]     words;
    } icache_frame_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL0 = 2'd1,
        FILL1 = 2'd2,
        HALT  = 2'd3
    } icache_state_t;

    // Byte address of one word of a block; the upper half of the bus is always zero.
    function automatic word_t fill_addr(input icache_tag_t tag, input icache_index_t idx,
                                        input logic off);
        return {(WORD_W-ADDR_SPACE_WIDTH)'(0), tag, idx, off, BYTE_OFF_W'(0)};
    endfunction

endpackage

// File: rtl/icache_responder_sat_counter16.sv
// Enabled 16-bit event counter that sticks at all-ones instead of wrapping.
module icache_responder_sat_counter16
    import icache_responder_pkg::*;
(
    input  logic             CLK,
    input  logic             nRST,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: same-cycle hit lookup, two-word block fill
// from memory on a miss, and a terminal HALT state entered on icache_halt.
module icache_responder
    import icache_responder_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic              icache_REN,
    input  logic [WORD_W-1:0] icache_addr,
    input  logic              icache_halt,
    output logic              icache_hit,
    output logic [WORD_W-1:0] icache_load,
    output logic              mem_REN,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [WORD_W-1:0] mem_load,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    icache_state_t r_state;
    icache_state_t w_next_state;

    icache_frame_t r_frames [ICACHE_FRAMES];
    icache_tag_t   r_miss_tag;
    icache_index_t r_miss_index;
    word_t         r_word0;

    icache_tag_t   w_tag;
    icache_index_t w_index;
    logic          w_offset;
    icache_frame_t w_frame;
    logic          w_match;
    logic          w_req;
    logic          w_miss_start;
    logic          w_cap_word0;
    logic          w_fill_write;
    icache_frame_t w_fill_frame;
    logic          w_unused_addr_bits;

    // Address decode within the 16-bit space.
    assign w_tag    = icache_addr[ADDR_SPACE_WIDTH-1 -: ICACHE_TAG_W];
    assign w_index  = icache_addr[BYTE_OFF_W+BLOCK_OFF_W +: LOG_ICACHE_FRAMES];
    assign w_offset = icache_addr[BYTE_OFF_W];
    assign w_unused_addr_bits = ^{icache_addr[WORD_W-1:ADDR_SPACE_WIDTH],
                                  icache_addr[BYTE_OFF_W-1:0]};

    assign w_frame     = r_frames[w_index];
    assign w_match     = w_frame.valid && (w_frame.tag == w_tag);
    assign w_req       = icache_REN && !icache_halt;
    assign icache_load = w_frame.words[w_offset];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Halt overrides everything; fills run to completion regardless of new requests.
    always_comb begin
        w_next_state = r_state;
        if (icache_halt) begin
            w_next_state = HALT;
        end else begin
            case (r_state)
                IDLE:    if (icache_REN && !w_match) w_next_state = FILL0;
                FILL0:   if (mem_ready)              w_next_state = FILL1;
                FILL1:   if (mem_ready)              w_next_state = IDLE;
                HALT:                                w_next_state = HALT;
                default:                             w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        icache_hit   = 1'b0;
        mem_REN      = 1'b0;
        mem_addr     = '0;
        w_miss_start = 1'b0;
        w_cap_word0  = 1'b0;
        w_fill_write = 1'b0;
        case (r_state)
            IDLE: begin
                icache_hit   = w_req && w_match;
                w_miss_start = w_req && !w_match;
            end
            FILL0: begin
                mem_REN     = 1'b1;
                mem_addr    = fill_addr(r_miss_tag, r_miss_index, 1'b0);
                w_cap_word0 = mem_ready && !icache_halt;
            end
            FILL1: begin
                mem_REN      = 1'b1;
                mem_addr     = fill_addr(r_miss_tag, r_miss_index, 1'b1);
                w_fill_write = mem_ready && !icache_halt;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        w_fill_frame       = '0;
        w_fill_frame.valid = 1'b1;
        w_fill_frame.tag   = r_miss_tag;
        w_fill_frame.words = {mem_load, r_word0};
    end

    // Miss latch, first-word buffer and frame array; the frame is written whole at the end.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < int'(ICACHE_FRAMES); i++) begin
                r_frames[i] <= '0;
            end
            r_miss_tag   <= '0;
            r_miss_index <= '0;
            r_word0      <= '0;
        end else begin
            if (w_miss_start) begin
                r_miss_tag   <= w_tag;
                r_miss_index <= w_index;
            end
            if (w_cap_word0) begin
                r_word0 <= mem_load;
            end
            if (w_fill_write) begin
                r_frames[r_miss_index] <= w_fill_frame;
            end
        end
    end

    icache_responder_sat_counter16 u_hit_counter (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_en    (icache_hit),
        .o_count (hit_count)
    );

    icache_responder_sat_counter16 u_miss_counter (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_en    (w_miss_start),
        .o_count (miss_count)
    );

endmodule
